// File: rtl/fmdll_edge_sequencer.sv
// Edge-select sequencer for the FMDLL delay line: owns the N/M counters,
// shadows the N/M configuration and drives the registered 2-bit line select.
module fmdll_edge_sequencer #(
  parameter int NW  = 4,
  parameter int MW  = 2,
  parameter int TMO = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [NW-1:0] n_cfg,
  input  logic [MW-1:0] m_cfg,
  input  logic          cfg_load,
  output logic          cfg_ack,
  output logic          err_cfg,
  input  logic          ref_edge,
  output logic [1:0]    sel,
  output logic [NW-1:0] n_count,
  output logic [MW-1:0] m_count,
  output logic          frame_done,
  output logic          err_miss,
  output logic          err_early,
  output logic          busy
);

  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REF,
    S_RUN,
    S_ARM,
    S_INJECT
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d, n_sh_q, n_sh_d, pend_n_q, pend_n_d;
  logic [MW-1:0] m_q, m_d, m_sh_q, m_sh_d, pend_m_q, pend_m_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;
  logic [1:0]    sel_q, sel_d;
  logic          ack_q, ack_d, err_cfg_q, err_cfg_d;
  logic          done_q, done_d, miss_q, miss_d, early_q, early_d, busy_q, busy_d;
  logic          cfg_valid, load_open, take_now, take_pend;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_d       = m_q;
    timer_d   = timer_q;
    miss_d    = 1'b0;
    early_d   = 1'b0;
    n_sh_d    = n_sh_q;
    m_sh_d    = m_sh_q;
    pend_d    = pend_q;
    pend_n_d  = pend_n_q;
    pend_m_d  = pend_m_q;
    sel_d     = 2'b00;

    case (state_q)
      S_IDLE: begin
        n_d = '0;
        m_d = '0;
        if (en) state_d = S_WAIT_REF;
      end
      S_WAIT_REF: begin
        n_d = '0;
        m_d = '0;
        // Disable takes priority over a coincident reference edge
        if (!en) begin
          state_d = S_IDLE;
        end else if (ref_edge) begin
          state_d = S_RUN;
          n_d     = NW'(1);
          m_d     = MW'(1);
        end
      end
      S_RUN: begin
        if (ref_edge) begin
          early_d = 1'b1;
          state_d = S_INJECT;
        end else if (n_q == n_sh_q) begin
          if (m_q < m_sh_q) begin
            n_d = NW'(1);
            m_d = m_q + 1'b1;
          end else begin
            state_d = S_ARM;
            timer_d = TW'(1);
          end
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      S_ARM: begin
        if (ref_edge) begin
          state_d = S_INJECT;
        end else if (timer_q == TW'(TMO)) begin
          miss_d  = 1'b1;
          state_d = S_WAIT_REF;
          n_d     = '0;
          m_d     = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_INJECT: begin
        if (en) begin
          state_d = S_RUN;
          n_d     = NW'(1);
          m_d     = MW'(1);
        end else begin
          state_d = S_IDLE;
          n_d     = '0;
          m_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        n_d     = '0;
        m_d     = '0;
      end
    endcase

    // A direct load supersedes any pending one; either path yields one ack
    cfg_valid = (n_cfg != '0) && (m_cfg != '0);
    load_open = (state_q == S_IDLE) || (state_q == S_WAIT_REF) || (state_q == S_INJECT);
    take_now  = cfg_load && cfg_valid && load_open;
    take_pend = pend_q && ((state_q == S_INJECT) || (state_d == S_IDLE));
    if (take_now) begin
      n_sh_d = n_cfg;
      m_sh_d = m_cfg;
    end else if (take_pend) begin
      n_sh_d = pend_n_q;
      m_sh_d = pend_m_q;
    end
    if (cfg_load && cfg_valid && !load_open) begin
      pend_d   = 1'b1;
      pend_n_d = n_cfg;
      pend_m_d = m_cfg;
    end else if (take_now || take_pend) begin
      pend_d = 1'b0;
    end
    ack_d     = take_now || take_pend;
    err_cfg_d = cfg_load && !cfg_valid;

    if (state_d == S_INJECT) begin
      sel_d = 2'b01;
    end else if ((state_d == S_RUN) && (n_d == n_sh_d) && (m_d < m_sh_d)) begin
      sel_d = 2'b10;
    end
    done_d = (state_d == S_INJECT);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      m_q       <= '0;
      timer_q   <= '0;
      n_sh_q    <= NW'(1);
      m_sh_q    <= MW'(1);
      pend_q    <= 1'b0;
      pend_n_q  <= '0;
      pend_m_q  <= '0;
      sel_q     <= 2'b00;
      ack_q     <= 1'b0;
      err_cfg_q <= 1'b0;
      done_q    <= 1'b0;
      miss_q    <= 1'b0;
      early_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      m_q       <= m_d;
      timer_q   <= timer_d;
      n_sh_q    <= n_sh_d;
      m_sh_q    <= m_sh_d;
      pend_q    <= pend_d;
      pend_n_q  <= pend_n_d;
      pend_m_q  <= pend_m_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      err_cfg_q <= err_cfg_d;
      done_q    <= done_d;
      miss_q    <= miss_d;
      early_q   <= early_d;
      busy_q    <= busy_d;
    end
  end

  assign sel        = sel_q;
  assign n_count    = n_q;
  assign m_count    = m_q;
  assign cfg_ack    = ack_q;
  assign err_cfg    = err_cfg_q;
  assign frame_done = done_q;
  assign err_miss   = miss_q;
  assign err_early  = early_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fmdll_edge_sequencer.sv
// Bench for fmdll_edge_sequencer: directed frame scenarios followed by random
// traffic, all checked against a frame-position reference model.
module tb_fmdll_edge_sequencer;
  localparam int NW  = 4;
  localparam int MW  = 2;
  localparam int TMO = 16;

  localparam int OFF  = 0;
  localparam int HUNT = 1;
  localparam int CNT  = 2;
  localparam int ARMD = 3;
  localparam int INJ  = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, cfg_load, ref_edge;
  logic [NW-1:0] n_cfg;
  logic [MW-1:0] m_cfg;
  logic          cfg_ack, err_cfg, frame_done, err_miss, err_early, busy;
  logic [1:0]    sel;
  logic [NW-1:0] n_count;
  logic [MW-1:0] m_count;

  always #5 clk = ~clk;

  fmdll_edge_sequencer #(.NW(NW), .MW(MW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .n_cfg(n_cfg), .m_cfg(m_cfg),
    .cfg_load(cfg_load), .cfg_ack(cfg_ack), .err_cfg(err_cfg),
    .ref_edge(ref_edge), .sel(sel), .n_count(n_count), .m_count(m_count),
    .frame_done(frame_done), .err_miss(err_miss), .err_early(err_early),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: a frame is a linear position 0 .. sh_n*sh_m-1; indices derive from it
  int md, pos, arm_cnt, sh_n, sh_m, pend_ok, pn, pm;
  int x_sel, x_n, x_m, x_ack, x_ecfg, x_done, x_miss, x_early, x_busy;

  int t1n[6] = '{1, 2, 3, 1, 2, 3};
  int t1m[6] = '{1, 1, 1, 2, 2, 2};
  int t1s[6] = '{0, 0, 2, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_update(input bit e, input bit ld, input int nc, input int mc,
                              input bit rf, input bit rn);
    int old;
    bit ok;
    bit direct;
    if (!rn) begin
      md = OFF; pos = 0; arm_cnt = 0; sh_n = 1; sh_m = 1; pend_ok = 0;
      x_ack = 0; x_ecfg = 0; x_early = 0; x_miss = 0;
    end else begin
      old = md;
      ok = (nc != 0) && (mc != 0);
      x_ack = 0; x_early = 0; x_miss = 0;
      x_ecfg = (ld && !ok) ? 1 : 0;
      direct = ld && ok && (old == OFF || old == HUNT || old == INJ);
      case (old)
        OFF:  if (e) md = HUNT;
        HUNT: begin
          if (!e) md = OFF;
          else if (rf) begin md = CNT; pos = 0; end
        end
        CNT: begin
          if (rf) begin x_early = 1; md = INJ; end
          else if (pos == sh_n * sh_m - 1) begin md = ARMD; arm_cnt = 1; end
          else pos++;
        end
        ARMD: begin
          if (rf) md = INJ;
          else if (arm_cnt == TMO) begin x_miss = 1; md = HUNT; end
          else arm_cnt++;
        end
        default: begin
          if (e) begin md = CNT; pos = 0; end
          else md = OFF;
        end
      endcase
      if (direct) begin
        sh_n = nc; sh_m = mc; pend_ok = 0; x_ack = 1;
      end else if (pend_ok != 0 && (old == INJ || (md == OFF && old != OFF))) begin
        sh_n = pn; sh_m = pm; pend_ok = 0; x_ack = 1;
      end
      if (ld && ok && (old == CNT || old == ARMD)) begin
        pend_ok = 1; pn = nc; pm = mc;
      end
    end
    x_done = (md == INJ) ? 1 : 0;
    x_busy = (md != OFF) ? 1 : 0;
    if (md == CNT || md == ARMD || md == INJ) begin
      x_n = pos % sh_n + 1;
      x_m = pos / sh_n + 1;
    end else begin
      x_n = 0;
      x_m = 0;
    end
    if (md == INJ) x_sel = 1;
    else if (md == CNT && (pos % sh_n == sh_n - 1) && (pos / sh_n < sh_m - 1)) x_sel = 2;
    else x_sel = 0;
  endtask

  task automatic step(input bit e, input bit ld, input int nc, input int mc,
                      input bit rf, input bit rn);
    en = e; cfg_load = ld; n_cfg = nc[NW-1:0]; m_cfg = mc[MW-1:0];
    ref_edge = rf; rst_n = rn;
    @(posedge clk);
    model_update(e, ld, nc, mc, rf, rn);
    #1;
    cyc++;
    chk("sel", 32'(sel), x_sel);
    chk("n_count", 32'(n_count), x_n);
    chk("m_count", 32'(m_count), x_m);
    chk("cfg_ack", 32'(cfg_ack), x_ack);
    chk("err_cfg", 32'(err_cfg), x_ecfg);
    chk("frame_done", 32'(frame_done), x_done);
    chk("err_miss", 32'(err_miss), x_miss);
    chk("err_early", 32'(err_early), x_early);
    chk("busy", 32'(busy), x_busy);
    $display("cyc %0d rst_n=%0b en=%0b ld=%0b n_cfg=%0d m_cfg=%0d ref=%0b -> sel=%b n=%0d m=%0d ack=%0b ecfg=%0b done=%0b miss=%0b early=%0b busy=%0b",
             cyc, rn, e, ld, nc, mc, rf, sel, n_count, m_count, cfg_ack, err_cfg,
             frame_done, err_miss, err_early, busy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, maxn, saw10, saw_ack, saw_done, refpct;
    rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; ref_edge = 1'b0; n_cfg = '0; m_cfg = '0;
    md = OFF; pos = 0; arm_cnt = 0; sh_n = 1; sh_m = 1; pend_ok = 0; pn = 0; pm = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(sel), 0);

    // Basic 3x2 frame
    step(0, 1, 3, 2, 0, 1);
    chk("t1_ack", 32'(cfg_ack), 1);
    step(1, 0, 0, 0, 0, 1);
    chk("t1_wait_busy", 32'(busy), 1);
    step(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1, 0, 0, 0, 0, 1);
      chk("t1_n", 32'(n_count), t1n[i]);
      chk("t1_m", 32'(m_count), t1m[i]);
      chk("t1_sel", 32'(sel), t1s[i]);
    end
    step(1, 0, 0, 0, 0, 1);
    chk("t1_arm_sel", 32'(sel), 0);
    chk("t1_arm_n", 32'(n_count), 3);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    chk("t1_inj_sel", 32'(sel), 1);
    chk("t1_done", 32'(frame_done), 1);
    step(1, 0, 0, 0, 0, 1);
    chk("t1_restart_n", 32'(n_count), 1);
    chk("t1_restart_m", 32'(m_count), 1);

    // ARM timeout
    repeat (6) step(1, 0, 0, 0, 0, 1);
    chk("t2_in_arm_n", 32'(n_count), 3);
    k = 0;
    while (err_miss !== 1'b1 && k < 40) begin
      step(1, 0, 0, 0, 0, 1);
      k++;
    end
    chk("t2_arm_cycles", k, TMO);
    chk("t2_sel", 32'(sel), 0);
    chk("t2_n_zero", 32'(n_count), 0);
    chk("t2_busy", 32'(busy), 1);

    // Early reference edge in a 4x3 frame
    step(1, 1, 4, 3, 0, 1);
    chk("t3_ack", 32'(cfg_ack), 1);
    step(1, 0, 0, 0, 1, 1);
    repeat (5) step(1, 0, 0, 0, 0, 1);
    chk("t3_at_n", 32'(n_count), 2);
    chk("t3_at_m", 32'(m_count), 2);
    step(1, 0, 0, 0, 1, 1);
    chk("t3_early", 32'(err_early), 1);
    chk("t3_inj_sel", 32'(sel), 1);
    step(1, 0, 0, 0, 0, 1);
    chk("t3_resync_n", 32'(n_count), 1);
    chk("t3_resync_m", 32'(m_count), 1);

    // Load during RUN is deferred to INJECT
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 5, 1, 0, 1);
    chk("t4_no_ack_run", 32'(cfg_ack), 0);
    k = 0; saw_ack = 0;
    while (frame_done !== 1'b1 && k < 60) begin
      step(1, 0, 0, 0, (md == ARMD), 1);
      if (cfg_ack === 1'b1) saw_ack = 1;
      k++;
    end
    chk("t4_no_early_ack", saw_ack, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("t4_ack", 32'(cfg_ack), 1);
    k = 0; maxn = 0; saw10 = 0;
    while (md != ARMD && k < 30) begin
      if (int'(n_count) > maxn) maxn = int'(n_count);
      if (sel === 2'b10) saw10 = 1;
      step(1, 0, 0, 0, 0, 1);
      k++;
    end
    chk("t4_maxn", maxn, 5);
    chk("t4_no_sel10", saw10, 0);

    // en dropped mid-RUN: frame still ends with INJECT before IDLE
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    k = 0; saw_done = 0;
    while (busy === 1'b1 && k < 60) begin
      step(0, 0, 0, 0, (md == ARMD), 1);
      if (frame_done === 1'b1) saw_done = 1;
      k++;
    end
    chk("t6_done_before_idle", saw_done, 1);
    chk("t6_idle_busy", 32'(busy), 0);

    // Rejected load, then the n=1 degenerate case
    step(0, 1, 0, 2, 0, 1);
    chk("t5_err_cfg", 32'(err_cfg), 1);
    chk("t5_no_ack", 32'(cfg_ack), 0);
    step(0, 1, 1, 3, 0, 1);
    chk("t5_ack", 32'(cfg_ack), 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    chk("t5_sel_m1", 32'(sel), 2);
    step(1, 0, 0, 0, 0, 1);
    chk("t5_sel_m2", 32'(sel), 2);
    step(1, 0, 0, 0, 0, 1);
    chk("t5_sel_m3", 32'(sel), 0);
    chk("t5_m3", 32'(m_count), 3);
    step(1, 0, 0, 0, 0, 1);
    chk("t5_arm_m", 32'(m_count), 3);

    // Reset during ARM with a pending load
    step(1, 1, 7, 2, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_n", 32'(n_count), 0);
    chk("t6_rst_sel", 32'(sel), 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    chk("t6_sh1_sel", 32'(sel), 0);
    step(1, 0, 0, 0, 0, 1);
    chk("t6_sh1_arm_n", 32'(n_count), 1);
    chk("t6_sh1_arm_m", 32'(m_count), 1);
    chk("t6_no_pend_ack", 32'(cfg_ack), 0);

    // Random traffic with varying reference-edge density
    for (int b = 0; b < 8; b++) begin
      refpct = (b % 3 == 0) ? 2 : ((b % 3 == 1) ? 10 : 40);
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(0, 19) != 0,
             $urandom_range(0, 15) == 0,
             ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 15)),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 99)) < refpct,
             $urandom_range(0, 299) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
